// File: rtl/tpu_bsg_if.sv
// rtl/tpu_bsg_if.sv - byte queue, line and status signals of the bit-stream generator
interface tpu_bsg_if #(
  parameter int DEPTH = 4
);
  logic                     g_clk_tx;
  logic                     tx_en;
  logic                     wr_en;
  logic [7:0]               wr_data;
  logic                     tx_out;
  logic                     busy;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     ovf;
  logic                     frame_done;

  modport master (
    output g_clk_tx, tx_en, wr_en, wr_data,
    input  tx_out, busy, full, empty, fifo_count, ovf, frame_done
  );

  modport slave (
    input  g_clk_tx, tx_en, wr_en, wr_data,
    output tx_out, busy, full, empty, fifo_count, ovf, frame_done
  );
endinterface

// File: rtl/tpu_bsg.sv
// rtl/tpu_bsg.sv - FIFO-fed serial bit-stream generator paced by g_clk_tx (even parity slot when TPU_BSG_PARITY_EN is defined)
module tpu_bsg #(
  parameter int DEPTH = 4
) (
  input  logic      sys_clock,
  input  logic      reset,
  tpu_bsg_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

`ifdef TPU_BSG_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          g_clk_tx_q;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          tx_out_r;
  logic          frame_done_r;
  logic          ovf_r;

  logic tick;
  logic full_w;
  logic empty_w;
  logic wr_accept;
  logic pop;

  // One slot boundary per rising edge of g_clk_tx, however long it stays high.
  assign tick      = bus.g_clk_tx & ~g_clk_tx_q;
  assign full_w    = (count == (AW+1)'(DEPTH));
  assign empty_w   = (count == '0);
  // A pop in the same cycle never makes room for a write arriving while full.
  assign wr_accept = bus.wr_en & ~full_w;
  assign pop       = tick & (state == IDLE) & bus.tx_en & ~empty_w;

  // Byte storage; no reset needed since occupancy is tracked by count.
  always_ff @(posedge sys_clock) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (bus.wr_en && full_w) begin
        ovf_r <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: every state and line change waits for a tick.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state        <= IDLE;
      g_clk_tx_q   <= 1'b0;
      tx_out_r     <= 1'b1;
      shreg        <= '0;
      bitcnt       <= '0;
      frame_done_r <= 1'b0;
    end else begin
      g_clk_tx_q   <= bus.g_clk_tx;
      frame_done_r <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (pop) begin
              shreg    <= mem[rd_ptr];
              tx_out_r <= 1'b0;
              bitcnt   <= '0;
              state    <= DATA;
            end else begin
              tx_out_r <= 1'b1;
            end
          end
          DATA: begin
            tx_out_r <= shreg[bitcnt];
            bitcnt   <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
`ifdef TPU_BSG_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef TPU_BSG_PARITY_EN
          PARITY: begin
            tx_out_r <= ^shreg;
            state    <= STOP;
          end
`endif
          STOP: begin
            tx_out_r     <= 1'b1;
            frame_done_r <= 1'b1;
            state        <= IDLE;
          end
          default: begin
            tx_out_r <= 1'b1;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_out     = tx_out_r;
  assign bus.busy       = (state != IDLE);
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.fifo_count = count;
  assign bus.ovf        = ovf_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: doc/tpu_bsg.md
# tpu_bsg

Bit-stream generator (BSG) fed by the TPU clock generator. Buffers transmit bytes in a small FIFO and serializes them onto a single line. One bit slot lasts from one rising edge of `g_clk_tx` to the next, so line timing follows the TPU `tx_slot` setting. Sits directly downstream of `tpu`: consumes `g_clk_tx`, takes its enable from a TPU control bit, and raises a per-frame completion pulse.

## Interface
- `DEPTH`, default 4: FIFO depth in bytes; must be a power of two, ≥2.
- `sys_clock` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `g_clk_tx` in 1: TPU modulation clock. Synchronous to `sys_clock`, held ≥1 cycle high and ≥1 cycle low. Sampled as data, never used as a clock.
- `tx_en` in 1: transmit enable, driven by a `tpu_control` bit.
- `wr_en` in 1: FIFO write strobe.
- `wr_data` in 8: byte to queue.
- `tx_out` out 1: serial line; idles high.
- `busy` out 1: frame in progress (`state != IDLE`).
- `full` out 1: FIFO holds `DEPTH` bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `fifo_count` out $clog2(DEPTH)+1: bytes queued.
- `ovf` out 1: sticky; set when a write is dropped because the FIFO is full.
- `frame_done` out 1: one-cycle pulse when the stop bit is driven.

## Operation
- Tick: `tick = g_clk_tx & ~g_clk_tx_q`, where `g_clk_tx_q` is `g_clk_tx` registered once. Every state change and every `tx_out` change happens only on a `sys_clock` edge in a tick cycle.
- Frame format: start bit 0, data bits LSB first, optional even parity bit, stop bit 1.
- FIFO: circular buffer with pointers that wrap modulo `DEPTH`.
  - A write is accepted when `wr_en` is high and `full` is low.
  - `wr_en` while `full` drops the byte and sets `ovf`. A pop in the same cycle does not make room.
  - A pop and an accepted write in the same cycle leave `fifo_count` unchanged.
- FSM (all transitions on tick only):
  - IDLE: if `tx_en` and not `empty`: pop head into `shreg`, `tx_out<=0` (start), `bitcnt<=0`, go to DATA. Otherwise `tx_out<=1`.
  - DATA: `tx_out<=shreg[bitcnt]`, `bitcnt++`. After driving bit 7, go to PARITY (parity build) or STOP.
  - PARITY: `tx_out<=^shreg`, go to STOP.
  - STOP: `tx_out<=1`, pulse `frame_done`, go to IDLE.
- The stop slot runs while the FSM is in IDLE. The next tick can start a new frame back-to-back, so a frame occupies 10 slots, or 11 with parity.
- `tx_en` falling mid-frame has no effect; the current frame completes. It is only checked in IDLE.
- Writes are accepted in every state, regardless of `tx_en`.

## Timing
- Reset values: `tx_out=1`, `busy=0`, `full=0`, `empty=1`, `fifo_count=0`, `ovf=0`, `frame_done=0`. Also cleared: FSM in IDLE, pointers 0, `g_clk_tx_q=0`.
- Reset mid-frame aborts immediately: `tx_out=1` on the next edge and queued bytes are discarded.
- Latency: `tx_out` updates on the `sys_clock` edge that ends the cycle in which `g_clk_tx` is first seen high.
- `fifo_count`, `full`, `empty` update on the edge following a write or pop.
- `frame_done` is high for exactly the one cycle after the stop-bit edge.
- A `g_clk_tx` that stays high generates only one tick.

## Configuration
- `TPU_BSG_PARITY_EN` defined: PARITY state is present; even parity bit after bit 7; frame is 11 slots.
- Not defined: PARITY state is absent; DATA goes straight to STOP; frame is 10 slots.

## Test plan
- Reset, write 0xA5, `tx_en=1`, `g_clk_tx` period 4 cycles (2 high / 2 low) -> `tx_out` per slot: 0,1,0,1,0,0,1,0,1,1. With parity: 0,1,0,1,0,0,1,0,1,0,1. `frame_done` pulses once.
- Write 0x01, 0x80 back-to-back -> second start bit in the slot right after the first stop bit; `busy` low only during the stop slot.
- DEPTH=4, `tx_en=0`, write 5 bytes -> `fifo_count=4`, `full=1`, `ovf=1`; the 5th byte is never transmitted.
- Drop `tx_en` during bit 3 of 0x3C -> frame completes; queued next byte waits until `tx_en` returns high.
- Assert `reset` during DATA -> `tx_out=1`, `empty=1`, `busy=0` after one edge; no `frame_done`.
- Hold `g_clk_tx` high for 20 cycles -> exactly one slot advance.
